// File: rtl/data_mem_responder.sv
// data_mem_responder: big-endian byte store with a pipelined read path,
// sticky range/alignment flags and a saturating count of committed writes.
module data_mem_responder #(
    parameter int MEM_BYTES    = 8192,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic [31:0]     mem_addr,
    input  logic [0:3][7:0] mem_data_in,
    input  logic            mem_write_en,
    input  logic            halted,
    output logic [0:3][7:0] mem_data_out,
    output logic            misaligned,
    output logic            out_of_range,
    output logic [31:0]     write_count
);
    localparam int AW = $clog2(MEM_BYTES);

    if (READ_LATENCY < 1 || READ_LATENCY > 4) begin : g_bad_latency
        $error("READ_LATENCY must be in 1..4");
    end
    if (MEM_BYTES < 4 || MEM_BYTES % 4 != 0) begin : g_bad_size
        $error("MEM_BYTES must be a positive multiple of 4");
    end

    logic [7:0]      mem [MEM_BYTES];
    logic [0:3][AW-1:0] idx;
    logic [0:3][7:0] rd;
    logic [0:3][7:0] stage [READ_LATENCY];
    logic            inrange;
    logic            wr;

    // Unsigned compare on the full address, so high addresses never wrap into low memory.
    always_comb begin
        inrange = mem_addr <= 32'(MEM_BYTES - 4);
        wr      = mem_write_en && !halted && inrange;
        for (int i = 0; i < 4; i++) begin
            idx[i] = AW'(mem_addr + 32'(i));
            rd[i]  = inrange ? mem[idx[i]] : 8'h00;
        end
    end

    // Store is not reset; lanes update independently so unaligned writes touch only their four bytes.
    always_ff @(posedge clk) begin
        if (wr)
            for (int i = 0; i < 4; i++)
                mem[idx[i]] <= mem_data_in[i];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            for (int k = 0; k < READ_LATENCY; k++)
                stage[k] <= '0;
            misaligned   <= 1'b0;
            out_of_range <= 1'b0;
            write_count  <= '0;
        end else begin
            stage[0] <= rd;
            for (int k = 1; k < READ_LATENCY; k++)
                stage[k] <= stage[k-1];
            misaligned   <= misaligned | (|mem_addr[1:0]);
            out_of_range <= out_of_range | !inrange;
            if (wr && write_count != '1)
                write_count <= write_count + 32'd1;
        end
    end

    assign mem_data_out = stage[READ_LATENCY-1];
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: directed stimulus with a queue-based read scoreboard
// and inline checks of the flags and write counter.
module tb_data_mem_responder;
    localparam int LAT = 2;
    localparam int MB  = 8192;

    logic            clk = 1'b0;
    logic            rst_b = 1'b0;
    logic [31:0]     mem_addr = 32'h10;
    logic [0:3][7:0] mem_data_in = '0;
    logic            mem_write_en = 1'b0;
    logic            halted = 1'b0;
    logic [0:3][7:0] mem_data_out;
    logic            misaligned;
    logic            out_of_range;
    logic [31:0]     write_count;

    typedef struct {
        int          due;
        logic [31:0] d;
        string       nm;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   tests = 0;
    int   fails = 0;

    data_mem_responder #(.MEM_BYTES(MB), .READ_LATENCY(LAT)) dut (
        .clk(clk), .rst_b(rst_b), .mem_addr(mem_addr), .mem_data_in(mem_data_in),
        .mem_write_en(mem_write_en), .halted(halted), .mem_data_out(mem_data_out),
        .misaligned(misaligned), .out_of_range(out_of_range), .write_count(write_count)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: compares read data on the cycle each expectation becomes due.
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].due <= cyc) begin
            tests++;
            if (q[0].due < cyc || mem_data_out !== q[0].d) begin
                fails++;
                $display("FAIL %s: got %h want %h (due %0d now %0d)", q[0].nm, mem_data_out, q[0].d, q[0].due, cyc);
            end
            void'(q.pop_front());
        end
    end

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        tests++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, got, want);
        end
    endtask

    // Present one access for exactly one edge; optionally expect its read data LAT edges later.
    task automatic acc(input logic [31:0] a, input logic [31:0] d, input logic we, input logic h,
                       input logic push, input logic [31:0] e, input string nm);
        @(posedge clk);
        #1;
        mem_addr     = a;
        mem_data_in  = d;
        mem_write_en = we;
        halted       = h;
        if (push) q.push_back('{cyc + LAT, e, nm});
    endtask

    task automatic idle();
        @(posedge clk);
        #1;
        mem_write_en = 1'b0;
        halted       = 1'b0;
    endtask

    task automatic flags(input string nm, input logic mis, input logic oor, input logic [31:0] wc);
        @(negedge clk);
        chk({nm, "_mis"}, {31'd0, misaligned}, {31'd0, mis});
        chk({nm, "_oor"}, {31'd0, out_of_range}, {31'd0, oor});
        chk({nm, "_wc"}, write_count, wc);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_data", mem_data_out, 32'h0);
        flags("rst", 1'b0, 1'b0, 32'd0);
        #1 rst_b = 1'b1;
        acc(32'h10, 32'h01020304, 1, 0, 0, 0, "");
        acc(32'h14, 32'h0A0B0C0D, 1, 0, 0, 0, "");
        acc(32'h10, 0, 0, 0, 1, 32'h01020304, "lat_r10a");
        acc(32'h14, 0, 0, 0, 1, 32'h0A0B0C0D, "lat_r14");
        acc(32'h10, 0, 0, 0, 1, 32'h01020304, "lat_r10b");
        idle();
        flags("post_rst", 1'b0, 1'b0, 32'd2);
        acc(32'h40, 32'hDEADBEEF, 1, 0, 0, 0, "");
        acc(32'h40, 0, 0, 0, 1, 32'hDEADBEEF, "wr_rd_40");
        acc(32'h80, 32'h11223344, 1, 0, 0, 0, "");
        acc(32'h80, 32'hAABBCCDD, 1, 0, 1, 32'h11223344, "rbw_old");
        acc(32'h80, 0, 0, 0, 1, 32'hAABBCCDD, "rbw_new");
        idle();
        flags("wr", 1'b0, 1'b0, 32'd5);
        acc(32'h40, 32'hFFFFFFFF, 1, 1, 1, 32'hDEADBEEF, "halt_pre");
        acc(32'h40, 0, 0, 0, 1, 32'hDEADBEEF, "halt_post");
        idle();
        flags("halt", 1'b0, 1'b0, 32'd5);
        acc(32'h44, 32'h55667788, 1, 0, 0, 0, "");
        acc(32'h42, 32'h01020304, 1, 0, 0, 0, "");
        acc(32'h40, 0, 0, 0, 1, 32'hDEAD0102, "mis_r40");
        acc(32'h44, 0, 0, 0, 1, 32'h03047788, "mis_r44");
        acc(32'h42, 0, 0, 0, 1, 32'h01020304, "mis_r42");
        idle();
        flags("mis", 1'b1, 1'b0, 32'd7);
        acc(32'h1FFC, 32'hCAFEF00D, 1, 0, 0, 0, "");
        acc(32'h0, 32'h12345678, 1, 0, 0, 0, "");
        acc(32'h1FFC, 0, 0, 0, 1, 32'hCAFEF00D, "bnd_1ffc");
        idle();
        flags("bnd_ok", 1'b1, 1'b0, 32'd9);
        acc(32'h1FFD, 32'h99999999, 1, 0, 1, 32'h0, "bnd_1ffd");
        acc(32'h1FFC, 0, 0, 0, 1, 32'hCAFEF00D, "bnd_keep");
        acc(32'hFFFFFFFE, 32'hEEEEEEEE, 1, 0, 1, 32'h0, "bnd_wrap_rd");
        acc(32'h0, 0, 0, 0, 1, 32'h12345678, "bnd_nowrap");
        idle();
        flags("bnd_oor", 1'b1, 1'b1, 32'd9);
        acc(32'h40, 0, 0, 0, 0, 0, "");
        acc(32'h80, 0, 0, 0, 0, 0, "");
        repeat (LAT + 2) idle();
        flags("sticky", 1'b1, 1'b1, 32'd9);
        acc(32'h40, 0, 0, 0, 0, 0, "");
        #3 rst_b = 1'b0;
        #1;
        chk("async_data", mem_data_out, 32'h0);
        chk("async_flags", {30'd0, misaligned, out_of_range}, 32'h0);
        chk("async_wc", write_count, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_b = 1'b1;
        acc(32'h80, 0, 0, 0, 1, 32'hAABBCCDD, "rst2_r80");
        repeat (LAT + 2) idle();
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/data_mem_responder.md
Name: data_mem_responder

Overview:
- Responder end of the core's data-memory interface: accepts `mem_addr`, write bytes and `mem_write_en` from `mips_core`, and returns four read bytes on `mem_data_out`.
- Holds a byte-addressed, big-endian store with a configurable read-pipeline latency.
- Tracks alignment and range errors, and counts committed writes.
- Sits beside `mips_core` in the top level, opposite the core's `mem_*` ports.

Parameters:
- MEM_BYTES, 8192: size of the byte store. Legal byte addresses are 0..MEM_BYTES-1. Must be a multiple of 4.
- READ_LATENCY, 1: clock edges from address sample to data valid on `mem_data_out`. Legal range 1..4; other values are an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_b  input  1  asynchronous active-low reset.
- mem_addr  input  32  byte address of the word access; lane i addresses byte mem_addr+i.
- mem_data_in  input  8 x [0:3]  write bytes from core; lane 0 is the most-significant byte.
- mem_write_en  input  1  write strobe, sampled on the rising edge of clk.
- halted  input  1  core halted; suppresses all writes.
- mem_data_out  output  8 x [0:3]  read bytes to core; lane 0 is the most-significant byte.
- misaligned  output  1  sticky: an access was seen with mem_addr[1:0] != 0.
- out_of_range  output  1  sticky: an access was seen with mem_addr+3 >= MEM_BYTES.
- write_count  output  32  number of committed writes, saturating.

Behaviour:
- Reset (rst_b low, asynchronous):
  - All read-pipeline stages, mem_data_out lanes, misaligned, out_of_range and write_count go to 0 immediately.
  - The byte store is not cleared; its contents are undefined until written.
  - Reset asserted mid-pipeline discards all in-flight reads.
  - The first read data after deassertion appears READ_LATENCY edges after the first post-reset edge.
- Range check:
  - inrange = (mem_addr <= MEM_BYTES-4), evaluated as unsigned 32-bit with no wrap.
  - When !inrange: the read captures 0x00 in every lane, the write is suppressed, and out_of_range sets at the edge.
- Alignment:
  - mem_addr[1:0] != 0 sets misaligned at the edge.
  - The access still proceeds using bytes mem_addr..mem_addr+3 if inrange; there is no rounding.
  - Both flags are evaluated every cycle, regardless of mem_write_en.
- Write: at a rising edge, when mem_write_en && !halted && inrange:
  - store[mem_addr+i] <= mem_data_in[i] for i = 0..3;
  - write_count increments by 1, saturating at 0xFFFF_FFFF.
  - With halted=1 there is no store change and no count change.
- Read:
  - Every edge, stage 0 captures store[mem_addr+i] (or 0 if !inrange).
  - Stage k captures stage k-1; mem_data_out = stage READ_LATENCY-1.
  - With READ_LATENCY=1, data for the address present before edge n is visible just after edge n.
  - The read is unconditional and pipelined, so a new address may be issued every cycle (throughput 1 per cycle).
- Read/write on the same edge and address: the read captures the pre-write contents (read-before-write). The new data is visible to an access sampled on the next edge.
- Overlapping misaligned writes: byte lanes update independently; bytes outside mem_addr..mem_addr+3 are untouched.
- Sticky flags clear only on reset.
- No handshake toward the core: the responder never stalls. The core must account for READ_LATENCY.

Test Plan:
- Reset with READ_LATENCY=2: hold rst_b=0, mem_addr=0x10 -> mem_data_out all 0, flags 0, write_count=0. Release, read 0x10 after writing it -> data valid exactly 2 edges after the address edge.
- Write then read: write {DE,AD,BE,EF} at 0x40. Next cycle read 0x40 -> lanes [0:3] = DE,AD,BE,EF after READ_LATENCY edges. write_count=1.
- Same-edge read/write: 0x80 holds 11223344. Write AABBCCDD at 0x80 while reading 0x80 -> first output 11223344. Read on the following edge -> AABBCCDD.
- Halted write: halted=1, mem_write_en=1, write 0xFF bytes to 0x40 -> contents unchanged (DEADBEEF), write_count unchanged.
- Boundary (MEM_BYTES=8192):
  - write at 0x1FFC succeeds;
  - write at 0x1FFD -> suppressed, out_of_range=1, read returns 00000000;
  - mem_addr=0xFFFF_FFFE -> out_of_range=1 with no wrap to low memory.
- Misaligned: write 01020304 at 0x42 -> misaligned=1; bytes 0x42..0x45 = 01,02,03,04; bytes 0x40/0x41 = DE,AD unchanged. Flag stays 1 until rst_b low.
